// File: rtl/sub_borrow_serial.sv
// Digit-serial subtractor: {borrow, x - y - borrow_in}, p_DIGIT bits per clock, LSB digit first.
// Only a (p_DIGIT+1)-bit subtractor is used; the operands shift down past it one digit per cycle.
module sub_borrow_serial #(
  parameter int p_WIDTH = 8,
  parameter int p_DIGIT = 2
) (
  input  logic               iw_clk,
  input  logic               iw_rst_n,
  input  logic               iw_start,
  input  logic [p_WIDTH-1:0] iwv_x,
  input  logic [p_WIDTH-1:0] iwv_y,
  input  logic               iw_borrow,
  output logic               ow_busy,
  output logic               ow_done,
  output logic [p_WIDTH:0]   owv_diff
);

  localparam int N  = p_WIDTH / p_DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [p_WIDTH-1:0] x_sh;
  logic [p_WIDTH-1:0] y_sh;
  logic [p_WIDTH-1:0] res_sh;
  logic [p_WIDTH-1:0] res_next;
  logic               borrow;
  logic [CW-1:0]      cnt;
  logic [p_DIGIT:0]   step;
  logic               accept;

  // A negative digit result wraps, so its top bit is exactly the borrow out.
  always_comb begin
    step = {1'b0, x_sh[p_DIGIT-1:0]} - {1'b0, y_sh[p_DIGIT-1:0]}
         - {{p_DIGIT{1'b0}}, borrow};
  end

  generate
    if (p_DIGIT == p_WIDTH) begin : g_single
      assign res_next = step[p_DIGIT-1:0];
    end else begin : g_multi
      assign res_next = {step[p_DIGIT-1:0], res_sh[p_WIDTH-1:p_DIGIT]};
    end
  endgenerate

  assign accept  = iw_start && (state != S_RUN);
  assign ow_busy = (state == S_RUN);
  assign ow_done = (state == S_DONE);

  // owv_diff is written only on the final digit, so partial results never show.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state    <= S_IDLE;
      x_sh     <= '0;
      y_sh     <= '0;
      res_sh   <= '0;
      borrow   <= 1'b0;
      cnt      <= '0;
      owv_diff <= '0;
    end else if (accept) begin
      state  <= S_RUN;
      x_sh   <= iwv_x;
      y_sh   <= iwv_y;
      borrow <= iw_borrow;
      res_sh <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_RUN: begin
          x_sh   <= x_sh >> p_DIGIT;
          y_sh   <= y_sh >> p_DIGIT;
          borrow <= step[p_DIGIT];
          res_sh <= res_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= S_DONE;
            owv_diff <= {step[p_DIGIT], res_next};
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
